// File: rtl/sram8_word_ctrl.sv
// sram8_word_ctrl: serialises 32-bit native-bus word requests into byte-lane accesses on an 8-bit single-port SRAM
//   Parameters: SRAM_AW (SRAM byte-address width), LANES (byte lanes per word, fixed at 4)
//   Ports:
//     clk, resetn                          : clock (rising edge), asynchronous active-low reset
//     mem_valid, mem_sel, mem_addr,
//     mem_wdata, mem_wstrb                 : native bus request (wstrb == 0 means read)
//     mem_ready, mem_rdata                 : one-cycle completion pulse and read data
//     sram_ce, sram_oce, sram_wre,
//     sram_ad, sram_din                    : SRAM port (2K x 8, one-cycle read latency, bypass mode)
//     sram_dout                            : SRAM read data
//   Optional macro SRAM8_LANE_SKIP_EN: writes visit only strobed lanes, so write latency is 1 + popcount(wstrb).
module sram8_word_ctrl #(
  parameter int SRAM_AW = 11,
  parameter int LANES   = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               mem_valid,
  input  logic               mem_sel,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic [3:0]         mem_wstrb,
  output logic               mem_ready,
  output logic [31:0]        mem_rdata,
  output logic               sram_ce,
  output logic               sram_oce,
  output logic               sram_wre,
  output logic [SRAM_AW-1:0] sram_ad,
  output logic [7:0]         sram_din,
  input  logic [7:0]         sram_dout
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  state_t             r_state, w_state_n;
  logic [1:0]         r_lane, w_lane_n, w_first, w_next;
  logic [SRAM_AW-3:0] r_word, w_word;
  logic [31:0]        r_wdata, w_wdata;
  logic [3:0]         r_wstrb, w_wstrb;
  logic               w_idle, w_acc, w_go, w_rd, w_more;
  logic               r_p1_v, r_p2_v;
  logic [1:0]         r_p1_l, r_p2_l;
  logic               w_unused;
  assign w_unused = ^{mem_addr[31:SRAM_AW], mem_addr[1:0]};
  // In IDLE the first lane is driven straight from the bus so that it appears on the SRAM port one edge after T0.
  assign w_idle  = (r_state == S_IDLE);
  assign w_acc   = w_idle && mem_valid && mem_sel && !mem_ready;
  assign w_word  = w_idle ? mem_addr[SRAM_AW-1:2] : r_word;
  assign w_wdata = w_idle ? mem_wdata : r_wdata;
  assign w_wstrb = w_idle ? mem_wstrb : r_wstrb;
  assign w_rd    = ~|w_wstrb;
`ifdef SRAM8_LANE_SKIP_EN
  function automatic logic [1:0] f_low(input logic [3:0] m);
    f_low = 2'd0;
    for (int i = 3; i >= 0; i--) if (m[i]) f_low = 2'(i);
  endfunction
  logic [3:0] w_above;
  // Strobed lanes strictly above the one currently on the port.
  assign w_above = r_wstrb & (4'b1110 << r_lane);
  assign w_first = w_rd ? 2'd0 : f_low(w_wstrb);
  assign w_more  = w_rd ? (r_lane != 2'(LANES-1)) : |w_above;
  assign w_next  = w_rd ? r_lane + 2'd1 : f_low(w_above);
`else
  assign w_first = 2'd0;
  assign w_more  = (r_lane != 2'(LANES-1));
  assign w_next  = r_lane + 2'd1;
`endif
  always_comb begin
    w_state_n = r_state;
    w_lane_n  = r_lane;
    w_go      = 1'b0;
    case (r_state)
      S_IDLE: if (w_acc) begin
        w_state_n = S_ISSUE;
        w_lane_n  = w_first;
        w_go      = 1'b1;
      end
      S_ISSUE: if (w_more) begin
        w_lane_n = w_next;
        w_go     = 1'b1;
      end else w_state_n = w_rd ? S_DRAIN : S_DONE;
      S_DRAIN: w_state_n = S_DONE;
      default: w_state_n = S_IDLE;
    endcase
  end
  // r_p1 tracks the read lane currently on the port, r_p2 the lane whose byte is now on sram_dout.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_lane    <= 2'd0;
      r_word    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_p1_v    <= 1'b0;
      r_p1_l    <= 2'd0;
      r_p2_v    <= 1'b0;
      r_p2_l    <= 2'd0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      sram_ce   <= 1'b0;
      sram_oce  <= 1'b1;
      sram_wre  <= 1'b0;
      sram_ad   <= '0;
      sram_din  <= '0;
    end else begin
      r_state   <= w_state_n;
      r_lane    <= w_lane_n;
      if (w_acc) begin
        r_word  <= mem_addr[SRAM_AW-1:2];
        r_wdata <= mem_wdata;
        r_wstrb <= mem_wstrb;
      end
      sram_ce   <= w_go & (w_rd | w_wstrb[w_lane_n]);
      sram_wre  <= w_go & ~w_rd & w_wstrb[w_lane_n];
      sram_oce  <= 1'b1;
      if (w_go) sram_ad <= {w_word, w_lane_n};
      if (w_go & ~w_rd) sram_din <= w_wdata[8*w_lane_n +: 8];
      r_p1_v    <= w_go & w_rd;
      r_p1_l    <= w_lane_n;
      r_p2_v    <= r_p1_v;
      r_p2_l    <= r_p1_l;
      if (r_p2_v) mem_rdata[8*r_p2_l +: 8] <= sram_dout;
      mem_ready <= (w_state_n == S_DONE);
    end
  end
endmodule

// File: tb/tb_sram8_word_ctrl.sv
// tb_sram8_word_ctrl: randomized self-checking bench for sram8_word_ctrl against a word-level memory model
module tb_sram8_word_ctrl;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0, mem_sel = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        sram_ce, sram_oce, sram_wre;
  logic [10:0] sram_ad;
  logic [7:0]  sram_din, sram_dout;
  logic [7:0]  sram_arr [2048];
  logic [7:0]  ref_mem [2048];
  int          vectors = 0, miscompares = 0, stray = 0;
  bit          busy = 1'b0;
`ifdef SRAM8_LANE_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  always #5 clk = ~clk;
  sram8_word_ctrl dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .sram_ce(sram_ce), .sram_oce(sram_oce), .sram_wre(sram_wre),
    .sram_ad(sram_ad), .sram_din(sram_din), .sram_dout(sram_dout)
  );
  // SRAM primitive: address sampled on the edge, read data visible right after it.
  always @(posedge clk)
    if (sram_ce) begin
      if (sram_wre) sram_arr[sram_ad] <= sram_din;
      else sram_dout <= sram_arr[sram_ad];
    end
  // Any SRAM enable or ready pulse outside a bench-issued request is illegal.
  always @(negedge clk)
    if (!busy && (sram_ce || mem_ready)) stray++;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                        input bit scramble, output logic [31:0] rd);
    logic [8:0]  w;
    logic [10:0] a_ad [8];
    logic        a_wre [8];
    logic [7:0]  a_din [8];
    int          a_idx [8];
    int          n_acc, rdy, rank, exp_lat, exp_n, e_idx;
    logic [10:0] e_ad;
    logic        e_wre;
    logic [7:0]  e_din;
    logic [31:0] exp_rd;
    w = addr[10:2];
    rd = '0;
    exp_rd = {ref_mem[{w, 2'd3}], ref_mem[{w, 2'd2}], ref_mem[{w, 2'd1}], ref_mem[{w, 2'd0}]};
    @(negedge clk);
    busy = 1'b1;
    mem_valid = 1'b1; mem_sel = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = strb;
    @(posedge clk);
    #1;
    if (scramble) begin
      mem_valid = 1'($urandom);
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      mem_wstrb = 4'($urandom);
    end
    n_acc = 0;
    rdy = -1;
    for (int i = 0; i < 20 && rdy < 0; i++) begin
      @(negedge clk);
      if (sram_ce && n_acc < 8) begin
        a_ad[n_acc] = sram_ad; a_wre[n_acc] = sram_wre; a_din[n_acc] = sram_din; a_idx[n_acc] = i;
        n_acc++;
      end
      if (mem_ready) begin
        rdy = i;
        rd = mem_rdata;
        mem_valid = 1'b0; mem_sel = 1'b0;
      end
    end
    mem_valid = 1'b0; mem_sel = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_width addr=%h: ready still %b one cycle later, want 0", addr, mem_ready);
    end
    busy = 1'b0;
    exp_lat = (strb == 4'd0) ? 6 : (SKIP ? 1 + $countones(strb) : 5);
    vectors++;
    if (rdy + 1 != exp_lat) begin
      miscompares++;
      $display("FAIL latency addr=%h strb=%b: got %0d cycles (0 = timeout), want %0d", addr, strb, rdy + 1, exp_lat);
    end
    exp_n = (strb == 4'd0) ? 4 : $countones(strb);
    vectors++;
    if (n_acc != exp_n) begin
      miscompares++;
      $display("FAIL access_count addr=%h strb=%b: got %0d enabled cycles, want %0d", addr, strb, n_acc, exp_n);
    end
    rank = 0;
    for (int k = 0; k < 4; k++)
      if (strb == 4'd0 || strb[k]) begin
        e_ad  = {w, 2'(k)};
        e_wre = (strb != 4'd0);
        e_din = wdata[8*k +: 8];
        e_idx = (e_wre && SKIP) ? rank : k;
        vectors++;
        if (rank >= n_acc || a_ad[rank] !== e_ad || a_wre[rank] !== e_wre ||
            (e_wre && a_din[rank] !== e_din) || a_idx[rank] != e_idx) begin
          miscompares++;
          $display("FAIL lane%0d addr=%h strb=%b: got ad=%h wre=%b din=%h cyc=%0d, want ad=%h wre=%b din=%h cyc=%0d",
                   k, addr, strb, a_ad[rank], a_wre[rank], a_din[rank], a_idx[rank], e_ad, e_wre, e_din, e_idx);
        end
        if (strb[k]) ref_mem[{w, 2'(k)}] = wdata[8*k +: 8];
        rank++;
      end
    if (strb == 4'd0) begin
      vectors++;
      if (rd !== exp_rd) begin
        miscompares++;
        $display("FAIL rdata addr=%h: got %h, want %h", addr, rd, exp_rd);
      end
    end
  endtask
  task automatic check_reset_values(input string name);
    vectors++;
    if ({mem_ready, mem_rdata, sram_ce, sram_wre, sram_ad, sram_din, sram_oce} !==
        {1'b0, 32'h0, 1'b0, 1'b0, 11'h0, 8'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL %s: got ready=%b rdata=%h ce=%b wre=%b ad=%h din=%h oce=%b, want 0/0/0/0/0/0/1",
               name, mem_ready, mem_rdata, sram_ce, sram_wre, sram_ad, sram_din, sram_oce);
    end
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    check_reset_values("reset_state");
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("idle_after_reset");
  endtask
  task automatic test_directed;
    logic [31:0] rd;
    do_txn(32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b0, rd);
    do_txn(32'h0000_0010, 32'h0, 4'b0000, 1'b0, rd);
    vectors++;
    if (rd !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL readback_full: got %h, want deadbeef", rd);
    end
    do_txn(32'h0000_0010, 32'h1122_3344, 4'b0100, 1'b0, rd);
    do_txn(32'h0000_0010, 32'h0, 4'b0000, 1'b0, rd);
    vectors++;
    if (rd !== 32'hDE22_BEEF) begin
      miscompares++;
      $display("FAIL readback_partial: got %h, want de22beef", rd);
    end
  endtask
  task automatic test_sel_off;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i > 0) begin
        vectors++;
        if (sram_ce !== 1'b0 || mem_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL sel_off cycle %0d: got ce=%b ready=%b, want 0/0", i, sram_ce, mem_ready);
        end
      end
      mem_valid = 1'b1; mem_sel = 1'b0;
      mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = 4'($urandom);
    end
    @(negedge clk);
    mem_valid = 1'b0;
  endtask
  task automatic test_reset_abort;
    logic [31:0] rd;
    @(negedge clk);
    busy = 1'b1;
    mem_valid = 1'b1; mem_sel = 1'b1; mem_addr = 32'h20; mem_wdata = 32'hCAFE_F00D; mem_wstrb = 4'hF;
    @(posedge clk);
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    mem_valid = 1'b0; mem_sel = 1'b0;
    #1;
    check_reset_values("abort_immediate");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (mem_ready !== 1'b0 || sram_ce !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_quiet cycle %0d: got ready=%b ce=%b, want 0/0", i, mem_ready, sram_ce);
      end
    end
    resetn = 1'b1;
    busy = 1'b0;
    do_txn(32'h20, 32'h0BAD_CAFE, 4'hF, 1'b0, rd);
    do_txn(32'h20, 32'h0, 4'h0, 1'b0, rd);
  endtask
  task automatic test_back_to_back;
    logic [31:0] rd, rd1, rd2, exp1, exp2;
    int r1, r2;
    do_txn(32'h7FC, $urandom, 4'hF, 1'b0, rd);
    exp1 = {ref_mem[11'h013], ref_mem[11'h012], ref_mem[11'h011], ref_mem[11'h010]};
    exp2 = {ref_mem[11'h7FF], ref_mem[11'h7FE], ref_mem[11'h7FD], ref_mem[11'h7FC]};
    rd1 = '0; rd2 = '0;
    @(negedge clk);
    busy = 1'b1;
    mem_valid = 1'b1; mem_sel = 1'b1; mem_addr = 32'h10; mem_wstrb = 4'h0;
    r1 = -1; r2 = -1;
    for (int i = 0; i < 40 && r2 < 0; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        if (r1 < 0) begin
          r1 = i; rd1 = mem_rdata; mem_addr = 32'h7FC;
        end else begin
          r2 = i; rd2 = mem_rdata;
        end
      end
    end
    mem_valid = 1'b0; mem_sel = 1'b0;
    @(negedge clk);
    busy = 1'b0;
    vectors++;
    if (r1 < 0 || r2 < 0 || r2 - r1 != 7) begin
      miscompares++;
      $display("FAIL b2b_spacing: got ready at %0d and %0d (-1 = missing), want 7 apart", r1, r2);
    end
    vectors++;
    if (rd1 !== exp1 || rd2 !== exp2) begin
      miscompares++;
      $display("FAIL b2b_rdata: got %h %h, want %h %h", rd1, rd2, exp1, exp2);
    end
  endtask
  task automatic test_random;
    logic [31:0] rd, a;
    logic [3:0]  s;
    for (int i = 0; i < 8; i++)
      do_txn({21'($urandom), 9'(9'h40 + i), 2'($urandom)}, $urandom, 4'hF, 1'b0, rd);
    for (int i = 0; i < 40; i++) begin
      a = {21'($urandom), 9'(9'h40 + $urandom_range(0, 7)), 2'($urandom)};
      s = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      do_txn(a, $urandom, s, 1'($urandom), rd);
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_sel_off();
    test_reset_abort();
    test_back_to_back();
    test_random();
    vectors++;
    if (stray != 0) begin
      miscompares++;
      $display("FAIL stray_activity: got %0d cycles with ce/ready outside a request, want 0", stray);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sram8_word_ctrl.md
Name: sram8_word_ctrl

Overview:
- Bus-side controller (initiator) for an 8-bit single-port synchronous block SRAM: 2K x 8, one-cycle read latency, bypass read mode.
- Accepts 32-bit word requests from the picorv32-style native memory bus (valid/ready, addr, wdata, wstrb, rdata).
- Serialises each request into byte-lane accesses on the SRAM port and reassembles read data.
- Sits between the bus address decoder and the SRAM primitive wrapper; it is the SRAM's only driver.

Parameters:
- SRAM_AW, 11, SRAM byte-address width; word index = mem_addr[SRAM_AW-1:2].
- LANES, 4, byte lanes per bus word; fixed at 4, present for documentation/assertions only.

Ports:
- clk  in  1  system clock; all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- mem_valid  in  1  bus request valid
- mem_sel  in  1  address decode hit for this SRAM; requests without it are ignored
- mem_addr  in  32  byte address; bits [1:0] ignored (word aligned)
- mem_wdata  in  32  write data, lane k = bits [8k+7:8k]
- mem_wstrb  in  4  byte write strobes; 4'b0000 = read
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  32  read data, valid while mem_ready=1
- sram_ce  out  1  SRAM clock enable
- sram_oce  out  1  SRAM output clock enable
- sram_wre  out  1  SRAM write enable
- sram_ad  out  SRAM_AW  SRAM byte address
- sram_din  out  8  SRAM write data
- sram_dout  in  8  SRAM read data

Behaviour:
- Reset: async on resetn=0. Clears state to IDLE; mem_ready=0, mem_rdata=0, sram_ce=0, sram_wre=0, sram_ad=0, sram_din=0, sram_oce=1. sram_oce is constant 1 after reset.
- All SRAM-side and bus-side outputs are registered.
- States:
  - IDLE: waits for mem_valid & mem_sel & !mem_ready. At T0 (first sampling edge) latches addr, wdata, wstrb, sets lane=0 and goes to ISSUE.
  - ISSUE: drives one lane per cycle, T1..T4.
    - sram_ad = {word, lane[1:0]}.
    - Read: ce=1, wre=0.
    - Write: ce = wstrb[lane], wre = wstrb[lane], din = lane byte. Unstrobed lanes still take a cycle with ce=0.
    - After lane 3: a read goes to DRAIN, a write goes to DONE.
  - DRAIN: one cycle (read only). sram_dout is sampled on the edge after each lane's issue, at T2..T5. Lane k byte is stored into mem_rdata[8k+7:8k].
  - DONE: mem_ready=1 for exactly one cycle, then IDLE.
- Latency, counted from the T0 edge to mem_ready high: read 6 cycles (ready during T6), write 5 cycles (ready during T5).
- mem_rdata holds its last value after ready. Writes do not modify mem_rdata.
- Request fields are captured at T0. Changes to mem_valid or other inputs mid-transaction are ignored, and the transaction completes. mem_ready is pulsed even if mem_valid has dropped.
- Back-to-back: IDLE may accept a new request on the cycle after the mem_ready pulse.
- Requests with mem_sel=0 never assert ce or ready.
- Reset mid-transaction: immediate abort, all outputs return to reset values, no ready pulse. A partially written word is left as-is.
- Between transactions: sram_ce=0 and sram_wre=0 whenever the block is not in ISSUE.

Optional Feature:
- Macro: SRAM8_LANE_SKIP_EN.
- Defined: during writes, ISSUE advances directly to the next strobed lane, so unstrobed lanes consume no cycle. Write latency = 1 + popcount(wstrb) cycles to ready (wstrb=4'b0001 gives ready at T2). Reads are unchanged.
- Undefined: fixed 4-cycle ISSUE for all writes, as specified above.

Test Plan:
- Write addr 0x0000_0010, wdata 0xDEAD_BEEF, wstrb 4'b1111 -> ce/wre high T1..T4 with ad 0x010..0x013, din EF,BE,AD,DE; ready during T5.
- Read back addr 0x10 -> ad 0x010..0x013 at T1..T4; ready during T6 with rdata 0xDEAD_BEEF.
- Write addr 0x10, wdata 0x1122_3344, wstrb 4'b0100, then read -> only ad 0x012 gets wre; rdata 0xDE22_BEEF. With SRAM8_LANE_SKIP_EN, write ready at T2.
- mem_valid=1 with mem_sel=0 for 10 cycles -> sram_ce=0 and mem_ready=0 throughout.
- resetn low at T3 of a write to addr 0x20 -> outputs at reset values immediately, no ready pulse; next request after release completes normally.
- Two back-to-back reads of addr 0x10 and 0x7FC, mem_valid held high -> two ready pulses 7 cycles apart with correct data each.
